ledg_seq_ctrl: RTL and testbench
================================

LEDG_SEQ_CTRL -- requirements
Module: ledg_seq_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 9, LED output width driven into the PIO slave.
REQ-002 SHALL have parameter NUM_STEPS, default 8, pattern table depth (power of two).
REQ-003 SHALL have parameter PRESCALE_W, default 24, step-duration counter width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports address in 4, chipselect in 1, write_n in 1, writedata in 32, readdata out 32: CPU Avalon-MM slave, zero wait states.
REQ-007 SHALL have ports m_address out 2, m_chipselect out 1, m_write_n out 1, m_writedata out 32: Avalon-MM master into the LED PIO.
REQ-008 SHALL have port seq_irq  out  1  wrap interrupt (only with LEDG_SEQ_IRQ_EN).

Function
REQ-009 SHALL decode CPU words: 0 CTRL (bit0 run, bit1 oneshot, bit2 irq_en), 1 STATUS (bit0 busy, bit1 wrap W1C, [6:4] step, read-only otherwise), 2 PRESCALE (PRESCALE_W bits), 3 LEN (last step index), 4 DIRECT (LED_W bits), 8..8+NUM_STEPS-1 PATTERN[i] (LED_W bits).
REQ-010 SHALL return readdata combinationally, zero-extended; unmapped addresses read 0.
REQ-011 SHALL implement FSM IDLE, ISSUE, HOLD; busy = state != IDLE.
REQ-012 IDLE -> ISSUE the cycle after a CPU write sets run from 0 to 1; step reset to 0.
REQ-013 ISSUE SHALL assert m_chipselect=1, m_write_n=0, m_address=0, m_writedata=zero-extended PATTERN[step] for exactly one cycle, load hold counter with PRESCALE, go HOLD.
REQ-014 HOLD SHALL decrement counter each cycle; at counter==0: if step==LEN, set wrap, then oneshot ? (clear run, IDLE) : (step=0, ISSUE); else step+1, ISSUE.
REQ-015 Step period SHALL be exactly PRESCALE+2 cycles between successive master writes.
REQ-016 LEN greater than NUM_STEPS-1 SHALL be clamped to NUM_STEPS-1 on write.
REQ-017 CPU write to DIRECT while IDLE SHALL issue one master write of DIRECT the next cycle; while busy it SHALL only be stored.
REQ-018 CPU write clearing run SHALL force IDLE next cycle; no master write in that cycle even if HOLD expires simultaneously; LEDs keep last value.
REQ-019 PATTERN/PRESCALE/LEN writes while busy SHALL take effect at the next ISSUE/HOLD load.
REQ-020 Master outputs SHALL be idle (m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0) in all cycles without a write.
REQ-021 Wrap set by hardware and W1C clear in the same cycle: set wins.

Reset
REQ-022 reset SHALL clear CTRL, STATUS, step, counter, DIRECT, LEN to 0, PRESCALE to 0, PATTERN[] to 0, FSM to IDLE, seq_irq to 0, master outputs idle.
REQ-023 reset mid-HOLD SHALL abort with no further master write.

Configuration
REQ-024 With LEDG_SEQ_IRQ_EN defined: seq_irq = wrap & irq_en, registered; CTRL bit2 read/write.
REQ-025 Without LEDG_SEQ_IRQ_EN: seq_irq port absent, CTRL bit2 reads 0, writes ignored.

Structure
REQ-026 Shared package ledg_seq_pkg SHALL hold register word-address constants, CTRL/STATUS bit indices and FSM state typedef.
REQ-027 Prescale counter SHALL be sub-module ledg_seq_tick (load, decrement, zero flag); pattern table stays in top.

Verification
REQ-028 PATTERN[0..2]=0x001,0x002,0x004, LEN=2, PRESCALE=3, run=1 -> master writes 0x001,0x002,0x004,0x001 spaced 5 cycles, first one cycle after CTRL write.
REQ-029 Same with oneshot=1 -> exactly 3 writes, then run=0, busy=0, wrap=1; STATUS write 0x2 clears wrap.
REQ-030 IDLE, DIRECT=0x1FF -> one master write 0x1FF next cycle; DIRECT=0x055 while busy -> no write.
REQ-031 Clear run in the cycle HOLD reaches 0 -> no master write, IDLE next cycle.
REQ-032 LEN write 0xF with NUM_STEPS=8 -> LEN reads 7; with LEDG_SEQ_IRQ_EN and irq_en=1 seq_irq rises one cycle after wrap.
REQ-033 reset asserted mid-HOLD -> all registers 0, master idle, no write after reset.

Source files
------------

// File: rtl/ledg_seq_pkg.sv
// ledg_seq_pkg -- definitions shared by the LED pattern sequencer.
//   Holds the CPU register word addresses, the CTRL/STATUS bit positions
//   and the sequencer FSM state type.
//   Optional feature macro: LEDG_SEQ_IRQ_EN (wrap interrupt, CTRL bit2).
package ledg_seq_pkg;

  // CPU register word addresses
  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_STATUS   = 4'd1;
  localparam logic [3:0] ADDR_PRESCALE = 4'd2;
  localparam logic [3:0] ADDR_LEN      = 4'd3;
  localparam logic [3:0] ADDR_DIRECT   = 4'd4;
  localparam logic [3:0] ADDR_PATTERN  = 4'd8;

  // CTRL bits
  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;

  // STATUS bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_WRAP     = 1;
  localparam int STAT_STEP_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/ledg_seq_tick.sv
// ledg_seq_tick -- step-duration counter for the LED sequencer.
//   Loads a prescale value, counts down by one per enabled cycle and
//   stops at zero.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     load        : load load_val (has priority over dec)
//     load_val    : value to load
//     dec         : decrement enable
//     zero        : counter is currently zero
//   Optional feature macro: none (LEDG_SEQ_IRQ_EN lives in the top).
module ledg_seq_tick #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [PRESCALE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - PRESCALE_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ledg_seq_ctrl.sv
// ledg_seq_ctrl -- LED pattern sequencer bridging a CPU Avalon-MM slave to
// the Avalon-MM slave of an LED PIO.
//   The CPU programs a pattern table, a step length (LEN) and a step
//   duration (PRESCALE); while running, the sequencer writes PATTERN[step]
//   into the PIO once every PRESCALE+2 cycles. DIRECT gives immediate
//   manual control of the LEDs while the sequencer is idle.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     address, chipselect, write_n, writedata, readdata
//                       : CPU slave, zero wait states, combinational read
//     m_address, m_chipselect, m_write_n, m_writedata
//                       : master into the LED PIO (write-only)
//     seq_irq           : registered wrap interrupt (LEDG_SEQ_IRQ_EN only)
//   Optional feature macro: LEDG_SEQ_IRQ_EN adds seq_irq and CTRL.irq_en.
module ledg_seq_ctrl
  import ledg_seq_pkg::*;
#(
  parameter int LED_W      = 9,
  parameter int NUM_STEPS  = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
`ifdef LEDG_SEQ_IRQ_EN
  ,
  output logic        seq_irq
`endif
);

  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  state_t                state, next_state;
  logic                  run, oneshot, wrap;
  logic [PRESCALE_W-1:0] prescale;
  logic [STEP_W-1:0]     len, step;
  logic [LED_W-1:0]      direct;
  logic [LED_W-1:0]      pattern [NUM_STEPS];
  logic                  direct_pend;
  logic                  tick_zero;
`ifdef LEDG_SEQ_IRQ_EN
  logic                  irq_en;
`endif

  // CPU write decode
  logic       wr, ctrl_wr, status_wr, prescale_wr, len_wr, direct_wr;
  logic       start, stop, hold_done, at_last, wrap_evt;
  logic [3:0] pat_off;
  logic       pat_hit;
  logic [STEP_W-1:0] pat_idx;

  assign wr          = chipselect && !write_n;
  assign ctrl_wr     = wr && (address == ADDR_CTRL);
  assign status_wr   = wr && (address == ADDR_STATUS);
  assign prescale_wr = wr && (address == ADDR_PRESCALE);
  assign len_wr      = wr && (address == ADDR_LEN);
  assign direct_wr   = wr && (address == ADDR_DIRECT);

  assign pat_off = address - ADDR_PATTERN;
  assign pat_hit = (address >= ADDR_PATTERN) && ({28'd0, pat_off} < 32'(NUM_STEPS));
  assign pat_idx = pat_off[STEP_W-1:0];

  // Only a 0->1 transition of run starts a sequence; rewriting run=1 while
  // running is harmless.
  assign start     = ctrl_wr && writedata[CTRL_RUN] && !run;
  assign stop      = ctrl_wr && !writedata[CTRL_RUN];
  assign hold_done = (state == S_HOLD) && tick_zero;
  // >= rather than == so that lowering LEN below the current step while
  // running still wraps instead of walking off the end of the table.
  assign at_last   = (step >= len);
  assign wrap_evt  = hold_done && at_last && !stop;

  ledg_seq_tick #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (state == S_ISSUE),
    .load_val (prescale),
    .dec      (state == S_HOLD),
    .zero     (tick_zero)
  );

  // Next-state logic; a CPU stop overrides every other transition so that
  // no master write can slip out in the cycle after run is cleared.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_ISSUE;
      S_ISSUE: next_state = S_HOLD;
      S_HOLD:  if (tick_zero) next_state = (at_last && oneshot) ? S_IDLE : S_ISSUE;
      default: next_state = S_IDLE;
    endcase
    if (stop) next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      run         <= 1'b0;
      oneshot     <= 1'b0;
      wrap        <= 1'b0;
      prescale    <= '0;
      len         <= '0;
      step        <= '0;
      direct      <= '0;
      direct_pend <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
`ifdef LEDG_SEQ_IRQ_EN
      irq_en      <= 1'b0;
      seq_irq     <= 1'b0;
`endif
    end else begin
      state <= next_state;

      if ((state == S_IDLE) && start) begin
        step <= '0;
      end else if (hold_done && (next_state == S_ISSUE)) begin
        step <= at_last ? '0 : step + STEP_W'(1);
      end

      // Hardware set beats a simultaneous write-one-to-clear.
      if (wrap_evt) begin
        wrap <= 1'b1;
      end else if (status_wr && writedata[STAT_WRAP]) begin
        wrap <= 1'b0;
      end

      if (wrap_evt && oneshot) run <= 1'b0;
      if (ctrl_wr) begin
        run     <= writedata[CTRL_RUN];
        oneshot <= writedata[CTRL_ONESHOT];
`ifdef LEDG_SEQ_IRQ_EN
        irq_en  <= writedata[CTRL_IRQ_EN];
`endif
      end

      if (prescale_wr) prescale <= writedata[PRESCALE_W-1:0];
      if (len_wr) begin
        if (writedata > 32'(NUM_STEPS - 1)) len <= STEP_W'(NUM_STEPS - 1);
        else                                len <= writedata[STEP_W-1:0];
      end
      if (direct_wr) direct <= writedata[LED_W-1:0];
      if (wr && pat_hit) pattern[pat_idx] <= writedata[LED_W-1:0];

      // DIRECT goes out the next cycle only when the sequencer owns nothing.
      direct_pend <= direct_wr && (state == S_IDLE);

`ifdef LEDG_SEQ_IRQ_EN
      seq_irq <= wrap && irq_en;
`endif
    end
  end

  // Master port: a write only in ISSUE or the cycle after a DIRECT write.
  always_comb begin
    m_address    = 2'd0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = 32'd0;
    if (state == S_ISSUE) begin
      m_chipselect = 1'b1;
      m_write_n    = 1'b0;
      m_writedata  = 32'(pattern[step]);
    end else if (direct_pend) begin
      m_chipselect = 1'b1;
      m_write_n    = 1'b0;
      m_writedata  = 32'(direct);
    end
  end

  // CPU read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN]     = run;
        readdata[CTRL_ONESHOT] = oneshot;
`ifdef LEDG_SEQ_IRQ_EN
        readdata[CTRL_IRQ_EN]  = irq_en;
`endif
      end
      ADDR_STATUS: begin
        readdata[STAT_BUSY]                = (state != S_IDLE);
        readdata[STAT_WRAP]                = wrap;
        readdata[STAT_STEP_LSB +: STEP_W]  = step;
      end
      ADDR_PRESCALE: readdata[PRESCALE_W-1:0] = prescale;
      ADDR_LEN:      readdata[STEP_W-1:0]     = len;
      ADDR_DIRECT:   readdata[LED_W-1:0]      = direct;
      default:       if (pat_hit) readdata[LED_W-1:0] = pattern[pat_idx];
    endcase
  end

endmodule

// File: tb/tb_ledg_seq_ctrl.sv
// tb_ledg_seq_ctrl -- directed bench for ledg_seq_ctrl (default parameters).
// Master writes are logged on the falling edge with the cycle number in
// which they were presented; expected data and spacing are hand-computed.
module tb_ledg_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
`ifdef LEDG_SEQ_IRQ_EN
  logic        seq_irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n0;
  int hits;
  logic [31:0] log_data [$];
  int          log_cyc  [$];

  ledg_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
`ifdef LEDG_SEQ_IRQ_EN
    ,
    .seq_irq      (seq_irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_chipselect && !m_write_n) begin
      log_data.push_back(m_writedata);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic check_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #0.5;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cs"}, {31'd0, m_chipselect}, 32'd0);
    check({tag, "_wn"}, {31'd0, m_write_n},    32'd1);
    check({tag, "_wd"}, m_writedata,           32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    cycles(3);
    reset = 1'b0;

    // Reset state
    check_rd("rst_ctrl",   4'd0, 32'h0);
    check_rd("rst_status", 4'd1, 32'h0);
    check_rd("rst_pres",   4'd2, 32'h0);
    check_rd("rst_len",    4'd3, 32'h0);
    check_rd("rst_direct", 4'd4, 32'h0);
    check_rd("rst_pat0",   4'd8, 32'h0);
    check_idle("rst_m");
`ifdef LEDG_SEQ_IRQ_EN
    check("rst_irq", {31'd0, seq_irq}, 32'd0);
`endif

    // Program and free-run: writes 1,2,4,1 spaced 5 cycles
    cpu_write(4'd8,  32'h001);
    cpu_write(4'd9,  32'h002);
    cpu_write(4'd10, 32'h004);
    cpu_write(4'd3,  32'd2);
    cpu_write(4'd2,  32'd3);
    check_rd("pat1_rd", 4'd9, 32'h002);
    cycles(1);
    log_data.delete(); log_cyc.delete();
    cpu_write(4'd0, 32'h1);
    n0 = cyc;
    check("run_first_cs", {31'd0, m_chipselect}, 32'd1);
    check("run_first_addr", {30'd0, m_address}, 32'd0);
    cycles(16);
    check("run_cnt", 32'(log_data.size()), 32'd4);
    check("run_d0", log_data[0], 32'h001);
    check("run_d1", log_data[1], 32'h002);
    check("run_d2", log_data[2], 32'h004);
    check("run_d3", log_data[3], 32'h001);
    check("run_c0", 32'(log_cyc[0] - n0), 32'd0);
    check("run_c1", 32'(log_cyc[1] - n0), 32'd5);
    check("run_c2", 32'(log_cyc[2] - n0), 32'd10);
    check("run_c3", 32'(log_cyc[3] - n0), 32'd15);
    cpu_write(4'd0, 32'h0);
    cycles(10);
    check("stop_cnt", 32'(log_data.size()), 32'd4);
    check_rd("stop_status", 4'd1, 32'h02);
    check_rd("stop_ctrl",   4'd0, 32'h0);
    cpu_write(4'd1, 32'h2);
    check_rd("w1c_status", 4'd1, 32'h00);

    // Oneshot: exactly three writes, step left at 2
    log_data.delete(); log_cyc.delete();
    cpu_write(4'd0, 32'h3);
    n0 = cyc;
    cycles(25);
    check("os_cnt", 32'(log_data.size()), 32'd3);
    check("os_d2",  log_data[2], 32'h004);
    check("os_c2",  32'(log_cyc[2] - n0), 32'd10);
    check_rd("os_ctrl",   4'd0, 32'h2);
    check_rd("os_status", 4'd1, 32'h22);
    cpu_write(4'd1, 32'h2);
    check_rd("os_w1c", 4'd1, 32'h20);

    // DIRECT while idle: one write the next cycle
    log_data.delete(); log_cyc.delete();
    cpu_write(4'd4, 32'h1FF);
    check("dir_cs", {31'd0, m_chipselect}, 32'd1);
    check("dir_wn", {31'd0, m_write_n},    32'd0);
    check("dir_wd", m_writedata,           32'h1FF);
    cycles(1);
    check_idle("dir_after");
    check_rd("dir_rd", 4'd4, 32'h1FF);
    check("dir_cnt", 32'(log_data.size()), 32'd1);

    // DIRECT while busy: stored only
    cpu_write(4'd0, 32'h1);
    cycles(1);
    log_data.delete(); log_cyc.delete();
    cpu_write(4'd4, 32'h055);
    cycles(5);
    cpu_write(4'd0, 32'h0);
    cycles(3);
    hits = 0;
    foreach (log_data[i]) if (log_data[i] == 32'h055) hits++;
    check("dir_busy_hits", 32'(hits), 32'd0);
    check_rd("dir_busy_rd", 4'd4, 32'h055);
    check_rd("dir_busy_idle", 4'd1, 32'h10);

    // Stop in the cycle HOLD reaches zero: no write, idle next cycle
    log_data.delete(); log_cyc.delete();
    cpu_write(4'd0, 32'h1);
    cycles(4);
    cpu_write(4'd0, 32'h0);
    check_idle("race_m");
    check_rd("race_status", 4'd1, 32'h00);
    cycles(8);
    check("race_cnt", 32'(log_data.size()), 32'd1);

    // LEN clamp and CTRL bit2
    cpu_write(4'd3, 32'hF);
    check_rd("len_clamp", 4'd3, 32'h7);
    cpu_write(4'd0, 32'h4);
`ifdef LEDG_SEQ_IRQ_EN
    check_rd("ctrl_b2", 4'd0, 32'h4);
    cpu_write(4'd3, 32'd2);
    cpu_write(4'd0, 32'h5);
    cycles(14);
    check_rd("irq_wrap_pre", 4'd1, 32'h01 | 32'h20);
    check("irq_pre", {31'd0, seq_irq}, 32'd0);
    cycles(1);
    check_rd("irq_wrap", 4'd1, 32'h03);
    check("irq_same", {31'd0, seq_irq}, 32'd0);
    cycles(1);
    check("irq_rise", {31'd0, seq_irq}, 32'd1);
    cpu_write(4'd0, 32'h0);
    cpu_write(4'd1, 32'h2);
`else
    check_rd("ctrl_b2", 4'd0, 32'h0);
`endif

    // Reset mid-HOLD
    cpu_write(4'd2, 32'd10);
    cpu_write(4'd0, 32'h1);
    cycles(3);
    check_rd("pre_rst_busy", 4'd1, 32'h01);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    log_data.delete(); log_cyc.delete();
    check_idle("mid_rst_m");
    cycles(20);
    check("mid_rst_cnt", 32'(log_data.size()), 32'd0);
    check_rd("mid_rst_ctrl",   4'd0,  32'h0);
    check_rd("mid_rst_status", 4'd1,  32'h0);
    check_rd("mid_rst_pres",   4'd2,  32'h0);
    check_rd("mid_rst_len",    4'd3,  32'h0);
    check_rd("mid_rst_direct", 4'd4,  32'h0);
    check_rd("mid_rst_pat0",   4'd8,  32'h0);
    check_rd("mid_rst_pat2",   4'd10, 32'h0);
`ifdef LEDG_SEQ_IRQ_EN
    check("mid_rst_irq", {31'd0, seq_irq}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
